lifo_reorder: RTL and testbench
===============================

LIFO_REORDER -- requirements
Module: lifo_reorder

Interface
REQ-001 The block SHALL have parameter BLK_LEN, default 8, meaning the traceback block length in decoded bits; legal values are powers of two from 2 to 64.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port wr_en, input, 1 bit: decoded-bit strobe from the traceback stage.
REQ-005 The block SHALL have port d_in, input, 1 bit: the decoded bit, emitted newest-first by traceback and sampled when wr_en=1.
REQ-006 The block SHALL have port dout_ready, input, 1 bit: downstream consumer accepts d_o this cycle.
REQ-007 The block SHALL have port d_o, output, 1 bit: reordered decoded bit, oldest-first; registered.
REQ-008 The block SHALL have port d_o_valid, output, 1 bit: d_o holds a valid bit; registered.
REQ-009 The block SHALL have port overflow, output, 1 bit: sticky flag, set when a write is dropped.

Function
REQ-010 Storage SHALL be two banks of BLK_LEN bits each (ping-pong), with a per-bank full flag, a write bank pointer wr_bank, a write counter wr_cnt (0..BLK_LEN-1), a read bank pointer rd_bank and a read counter rd_cnt.
REQ-011 When wr_en=1 and full[wr_bank]=0, d_in SHALL be stored at bank[wr_bank][BLK_LEN-1-wr_cnt], and wr_cnt SHALL then increment.
REQ-012 On the write where wr_cnt=BLK_LEN-1, the block SHALL set full[wr_bank], toggle wr_bank and wrap wr_cnt to 0, all on the same edge.
REQ-013 When wr_en=1 and full[wr_bank]=1 (registered value), the write SHALL be dropped, wr_cnt SHALL be unchanged, and overflow SHALL be set to 1 and held until reset.
REQ-014 The read FSM SHALL have exactly two states, IDLE and STREAM, and SHALL enter IDLE at reset.
REQ-015 In IDLE with full[rd_bank]=1, the next edge SHALL load d_o=bank[rd_bank][0], set d_o_valid=1, set rd_cnt=0 and enter STREAM; otherwise d_o_valid SHALL stay 0.
REQ-016 In STREAM, if d_o_valid=1 and dout_ready=1 and rd_cnt<BLK_LEN-1, rd_cnt SHALL increment and d_o SHALL load bank[rd_bank][rd_cnt+1].
REQ-017 In STREAM, if d_o_valid=1 and dout_ready=1 and rd_cnt=BLK_LEN-1, the block SHALL clear full[rd_bank], toggle rd_bank, set d_o_valid=0 and return to IDLE.
REQ-018 While d_o_valid=1 and dout_ready=0, d_o, rd_cnt and the state SHALL hold unchanged.
REQ-019 Latency SHALL be as follows: d_o_valid=1 on the edge after the edge that set full; one idle cycle between consecutive blocks; peak throughput is BLK_LEN bits per BLK_LEN+1 cycles.
REQ-020 When a bank is freed by REQ-017 on the same edge that a write targets it, that write SHALL be treated as full (dropped, overflow set); a bank freed on an edge SHALL be writable from the next cycle.
REQ-021 A write completing one bank on the same edge that a read frees the other bank SHALL perform both actions independently.
REQ-022 A partially filled bank SHALL never be read; no timeout or flush SHALL exist.
REQ-023 The block SHALL ignore d_in when wr_en=0.

Reset
REQ-024 When rst=0, asynchronously: d_o=0, d_o_valid=0, overflow=0, both full flags=0, wr_bank=0, rd_bank=0, wr_cnt=0, rd_cnt=0, FSM=IDLE.
REQ-025 Bank contents SHALL need no reset, and contents after reset SHALL be don't-care.
REQ-026 Reset asserted mid-block or mid-stream SHALL discard all buffered bits; the first block after reset release SHALL be handled normally.

Verification
REQ-027 Reversal: with BLK_LEN=8 and dout_ready=1, write 1,1,0,0,0,0,0,0 (first written first) -> d_o sequence 0,0,0,0,0,0,1,1, d_o_valid high for 8 consecutive cycles starting the cycle after the 8th write.
REQ-028 Backpressure: drop dout_ready for 3 cycles after the 3rd output bit -> d_o holds the 4th bit for those 3 cycles; all 8 bits are delivered in order with none lost or duplicated.
REQ-029 Back-to-back blocks: write 16 bits continuously with dout_ready=1 -> two correctly reversed 8-bit blocks, exactly one d_o_valid=0 cycle between them, overflow=0.
REQ-030 Overflow: dout_ready=0, write 17 bits -> overflow=1 after the 17th write; then dout_ready=1 yields exactly 16 correct bits; overflow stays 1.
REQ-031 Reset mid-stream: assert rst during the 4th output bit -> d_o=0, d_o_valid=0 immediately; after release, a fresh 8-bit block reverses correctly.
REQ-032 Partial block: 5 writes then wr_en=0 for 20 cycles -> d_o_valid stays 0; 3 further writes -> the block is output normally.

Source files
------------

// File: rtl/lifo_reorder.sv
// Ping-pong LIFO reorder buffer for a Viterbi traceback stage.
// Traceback delivers each block of BLK_LEN decoded bits newest-first; this
// block stores them mirrored into one of two banks and streams a completed
// bank back out oldest-first with a valid/ready handshake. A partially
// written bank is never read, and a write that finds its bank still full is
// dropped and recorded in the sticky overflow flag.
module lifo_reorder #(
  parameter int BLK_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic wr_en,
  input  logic d_in,
  input  logic dout_ready,
  output logic d_o,
  output logic d_o_valid,
  output logic overflow
);

  localparam int CW = $clog2(BLK_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(BLK_LEN - 1);
  localparam logic [CW-1:0] CNT_ZERO = '0;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t state, state_nxt;

  // Bit storage: no reset, contents are don't-care until written.
  logic [BLK_LEN-1:0] mem [2];

  logic [1:0]    full, full_nxt;
  logic          wr_bank, rd_bank;
  logic [CW-1:0] wr_cnt, rd_cnt, rd_cnt_inc, wr_idx;
  logic          wr_ok, wr_drop, wr_last;
  logic          ld_first, rd_adv, rd_done;

  // Write-side decode: the registered full flag alone decides acceptance,
  // so a bank freed on this edge is still treated as full for this write.
  always_comb begin
    wr_ok   = wr_en & ~full[wr_bank];
    wr_drop = wr_en &  full[wr_bank];
    wr_last = (wr_cnt == CNT_LAST);
    wr_idx  = CNT_LAST - wr_cnt;
  end

  // Read FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Read FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (full[rd_bank]) state_nxt = STREAM;
      STREAM:  if (d_o_valid && dout_ready && (rd_cnt == CNT_LAST)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read FSM output decode: which read-side action happens on this edge.
  always_comb begin
    ld_first   = 1'b0;
    rd_adv     = 1'b0;
    rd_done    = 1'b0;
    rd_cnt_inc = rd_cnt + 1'b1;
    case (state)
      IDLE:    ld_first = full[rd_bank];
      STREAM: begin
        rd_adv  = d_o_valid & dout_ready & (rd_cnt != CNT_LAST);
        rd_done = d_o_valid & dout_ready & (rd_cnt == CNT_LAST);
      end
      default: ;
    endcase
  end

  // Full flags: a read frees its bank and a completing write fills the
  // other one; both may happen on the same edge.
  always_comb begin
    full_nxt = full;
    if (rd_done) full_nxt[rd_bank] = 1'b0;
    if (wr_ok && wr_last) full_nxt[wr_bank] = 1'b1;
  end

  // Full flag register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) full <= 2'b00;
    else      full <= full_nxt;
  end

  // Mirrored bank write: the newest-first bit lands at the high end.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_bank][wr_idx] <= d_in;
  end

  // Write pointer, write counter and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt   <= '0;
      wr_bank  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        if (wr_last) begin
          wr_cnt  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_cnt  <= wr_cnt + 1'b1;
        end
      end
      if (wr_drop) overflow <= 1'b1;
    end
  end

  // Registered output stage: load, advance on handshake, or release bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_o       <= 1'b0;
      d_o_valid <= 1'b0;
      rd_cnt    <= '0;
      rd_bank   <= 1'b0;
    end else if (ld_first) begin
      d_o       <= mem[rd_bank][CNT_ZERO];
      d_o_valid <= 1'b1;
      rd_cnt    <= '0;
    end else if (rd_adv) begin
      d_o       <= mem[rd_bank][rd_cnt_inc];
      rd_cnt    <= rd_cnt_inc;
    end else if (rd_done) begin
      d_o_valid <= 1'b0;
      rd_bank   <= ~rd_bank;
    end
  end

endmodule

// File: tb/tb_lifo_reorder.sv
// Testbench for lifo_reorder: a block-level reference model turns accepted
// writes into reversed blocks on an expected-bit queue, and an independent
// monitor pops and compares on every output handshake.
module tb_lifo_reorder;

  localparam int BLK = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic wr_en = 1'b0;
  logic d_in = 1'b0;
  logic dout_ready = 1'b0;
  logic d_o, d_o_valid, overflow;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state (block level, no knowledge of bank encoding).
  logic part[$];
  logic exp_q[$];
  int   blk_done  = 0;
  int   blk_freed = 0;
  int   bits_out  = 0;
  int   n_pops    = 0;
  logic exp_ovf   = 1'b0;

  lifo_reorder #(.BLK_LEN(BLK)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .d_in       (d_in),
    .dout_ready (dout_ready),
    .d_o        (d_o),
    .d_o_valid  (d_o_valid),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a write is lost only when no bank is free for a new block,
  // i.e. nothing is partially written and two complete blocks are pending.
  always @(negedge clk) begin
    if (rst) begin
      chk("overflow_flag", 32'(overflow), 32'(exp_ovf));
      if (wr_en) begin
        if (part.size() == 0 && (blk_done - blk_freed) == 2) begin
          exp_ovf = 1'b1;
        end else begin
          part.push_back(d_in);
          if (part.size() == BLK) begin
            for (int i = BLK - 1; i >= 0; i--) exp_q.push_back(part[i]);
            part.delete();
            blk_done++;
          end
        end
      end
    end
  end

  // Monitor: every handshake consumes one expected bit.
  always begin
    @(negedge clk);
    #1;
    if (rst && d_o_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 32'(d_o_valid), 32'd0);
      end else begin
        logic e;
        e = exp_q.pop_front();
        chk("d_o_data", 32'(d_o), 32'(e));
      end
      n_pops++;
      bits_out++;
      if (bits_out == BLK) begin
        bits_out = 0;
        blk_freed++;
      end
    end
  end

  task automatic flush_model();
    part.delete();
    exp_q.delete();
    blk_done  = 0;
    blk_freed = 0;
    bits_out  = 0;
    exp_ovf   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    wr_en = 1'b0;
    d_in = 1'b0;
    dout_ready = 1'b0;
    flush_model();
    #1;
    chk("reset_state", {29'd0, d_o, d_o_valid, overflow}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic wr(input logic b);
    wr_en = 1'b1;
    d_in  = b;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    d_in  = 1'b0;
  endtask

  task automatic drain();
    int t;
    dout_ready = 1'b1;
    wr_en = 1'b0;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
    chk("valid_low_after_drain", 32'(d_o_valid), 32'd0);
  endtask

  initial begin
    logic [7:0]  in_seq;
    logic [7:0]  out_seq;
    logic        w[8];
    logic [29:0] tr, exp_tr;
    int          p0, cnt, stall;

    // Reversal and latency
    do_reset();
    dout_ready = 1'b1;
    in_seq  = 8'b0000_0011;
    out_seq = 8'b1100_0000;
    for (int i = 0; i < 8; i++) wr(in_seq[i]);
    chk("valid_not_yet", 32'(d_o_valid), 32'd0);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      chk("rev_valid", 32'(d_o_valid), 32'd1);
      chk("rev_bit", 32'(d_o), 32'(out_seq[k]));
    end
    @(posedge clk);
    #1;
    chk("rev_valid_end", 32'(d_o_valid), 32'd0);
    drain();

    // Backpressure: hold the 4th bit for 3 cycles
    do_reset();
    dout_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      w[i] = 1'($urandom);
      wr(w[i]);
    end
    repeat (4) @(posedge clk);
    #1;
    dout_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_valid", 32'(d_o_valid), 32'd1);
      chk("bp_hold_bit", 32'(d_o), 32'(w[4]));
    end
    p0 = n_pops;
    drain();
    chk("bp_total_bits", 32'(n_pops - p0 + 3), 32'd8);

    // Back-to-back blocks: exactly one idle cycle between them
    do_reset();
    dout_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 16; i++) wr(1'($urandom));
      end
      begin
        for (int j = 0; j < 30; j++) begin
          @(posedge clk);
          #2;
          tr[j] = d_o_valid;
        end
      end
    join
    for (int j = 0; j < 30; j++) exp_tr[j] = (j >= 8 && j <= 15) || (j >= 17 && j <= 24);
    chk("b2b_valid_trace", 32'(tr), 32'(exp_tr));
    drain();
    chk("b2b_no_overflow", 32'(overflow), 32'd0);

    // Overflow: 17 writes with the consumer stalled
    do_reset();
    dout_ready = 1'b0;
    for (int i = 0; i < 16; i++) wr(1'($urandom));
    chk("ovf_before_17th", 32'(overflow), 32'd0);
    wr(1'($urandom));
    chk("ovf_after_17th", 32'(overflow), 32'd1);
    p0 = n_pops;
    drain();
    chk("ovf_bits_delivered", 32'(n_pops - p0), 32'd16);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Reset in the middle of the stream
    do_reset();
    dout_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      w[i] = (i == 4) ? 1'b1 : 1'($urandom);
      wr(w[i]);
    end
    repeat (4) @(posedge clk);
    #1;
    chk("mid_4th_bit", 32'(d_o), 32'(w[4]));
    rst = 1'b0;
    flush_model();
    #1;
    chk("mid_reset_out", {30'd0, d_o, d_o_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    p0 = n_pops;
    for (int i = 0; i < 8; i++) wr(1'($urandom));
    drain();
    chk("mid_fresh_block_bits", 32'(n_pops - p0), 32'd8);

    // Partial block is never read until completed
    do_reset();
    dout_ready = 1'b1;
    for (int i = 0; i < 5; i++) wr(1'($urandom));
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (d_o_valid) cnt++;
    end
    chk("partial_no_valid", 32'(cnt), 32'd0);
    for (int i = 0; i < 3; i++) wr(1'($urandom));
    @(posedge clk);
    #1;
    chk("partial_then_valid", 32'(d_o_valid), 32'd1);
    drain();

    // Randomized traffic with bursty backpressure
    do_reset();
    stall = 0;
    for (int c = 0; c < 2000; c++) begin
      wr_en = (($urandom % 4) != 0);
      d_in  = 1'($urandom);
      if (stall == 0 && ($urandom % 24) == 0) stall = $urandom_range(5, 30);
      dout_ready = (stall == 0) && (($urandom % 4) != 0);
      if (stall > 0) stall--;
      @(posedge clk);
      #1;
    end
    wr_en = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
